alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_bit_slice.sv | 66 ++++++
 rtl/alu_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU datapath blocks:
//   - alu_op_e    : 3-bit opcode encoding
//   - alu_state_e : sequencer FSM state encoding
//   - op_is_sub   : helper, selects carry-in / b inversion for subtraction
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NOT  = 3'b011,
      OP_ADD  = 3'b100,
      OP_SUB  = 3'b101,
      OP_PASS = 3'b110,
      OP_RSVD = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } alu_state_e;

   // Subtraction is a + ~b + 1: b is inverted per bit and the carry starts at 1.
   function automatic logic op_is_sub(input alu_op_e op);
      return (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// -----------------------------------------------------------------------------
// alu_bit_slice
// One-bit ALU slice used by the bit-serial sequencer.
// Ports:
//   a, b  (in)  current operand bits
//   cin   (in)  carry into this bit
//   op    (in)  opcode (alu_op_e)
//   y     (out) result bit
//   cout  (out) carry out; only meaningful for ADD/SUB, 0 otherwise
// -----------------------------------------------------------------------------
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic    a,
   input  logic    b,
   input  logic    cin,
   input  alu_op_e op,
   output logic    y,
   output logic    cout
);

   logic is_sub_s;
   logic b_eff_s;
   logic and_s;
   logic or_s;
   logic xor_s;
   logic not_s;
   logic prop_s;
   logic gen_s;
   logic prop_c_s;
   logic sum_s;
   logic carry_s;

   assign is_sub_s = op_is_sub(op);

   // Logic functions
   and u_and  (and_s, a, b);
   or  u_or   (or_s,  a, b);
   xor u_xor  (xor_s, a, b);
   not u_not  (not_s, a);

   // Full adder on the (optionally inverted) b operand
   xor u_beff (b_eff_s, b, is_sub_s);
   xor u_prop (prop_s, a, b_eff_s);
   xor u_sum  (sum_s, prop_s, cin);
   and u_gen  (gen_s, a, b_eff_s);
   and u_pc   (prop_c_s, prop_s, cin);
   or  u_co   (carry_s, gen_s, prop_c_s);

   // Opcode output select; non-arithmetic ops force carry to 0
   always_comb begin
      y    = 1'b0;
      cout = 1'b0;
      case (op)
         OP_AND:  begin y = and_s; cout = 1'b0;    end
         OP_OR:   begin y = or_s;  cout = 1'b0;    end
         OP_XOR:  begin y = xor_s; cout = 1'b0;    end
         OP_NOT:  begin y = not_s; cout = 1'b0;    end
         OP_ADD:  begin y = sum_s; cout = carry_s; end
         OP_SUB:  begin y = sum_s; cout = carry_s; end
         OP_PASS: begin y = a;     cout = 1'b0;    end
         default: begin y = 1'b0;  cout = 1'b0;    end
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Bit-serial ALU sequencer: accepts one request, runs alu_bit_slice over the
// operands LSB first (one bit per clock), then holds the result until taken.
// Parameter:
//   WIDTH      operand/result width (2..32)
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   request present on op/a/b
//   in_ready   block idle and able to accept (1 only in IDLE)
//   op, a, b   opcode and operands
//   out_valid  result/flags valid (DONE)
//   out_ready  consumer accepts result
//   result     operation result
//   carry_out  final carry for ADD/SUB (SUB: 1 = no borrow), else 0
//   zero       result == 0
// -----------------------------------------------------------------------------
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero
);

   // Counter is wide enough to hold WIDTH itself, so it never wraps.
   localparam int CNT_W = $clog2(WIDTH + 1);

   alu_state_e       state_q,     state_d;
   alu_op_e          op_q,        op_d;
   logic [WIDTH-1:0] a_q,         a_d;
   logic [WIDTH-1:0] b_q,         b_d;
   logic [WIDTH-1:0] res_q,       res_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             carry_q,     carry_d;
   logic             zero_q,      zero_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q,  in_ready_d;

   logic             y_s;
   logic             cout_s;

   alu_bit_slice u_slice (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .op   (op_q),
      .y    (y_s),
      .cout (cout_s)
   );

   // Next-state and datapath update for the IDLE/RUN/DONE sequencer
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               op_d       = alu_op_e'(op);
               a_d        = a;
               b_d        = b;
               res_d      = '0;
               cnt_d      = '0;
               carry_d    = op_is_sub(alu_op_e'(op));
               in_ready_d = 1'b0;
               state_d    = ST_RUN;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Result bits enter at the MSB so the LSB-first stream ends aligned.
            res_d   = {y_s, res_q[WIDTH-1:1]};
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = cout_s;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               zero_d      = (res_d == '0);
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               state_d     = ST_RUN;
            end
         end
         ST_DONE: begin
            // Returning to IDLE leaves in_ready low this cycle, so no
            // request can be taken on the same edge as the output handshake.
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_DONE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_AND;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = res_q;
   assign carry_out = carry_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Scoreboard bench for alu_seq_ctrl (WIDTH=8): a driver pushes the expected
// response of each accepted request into a queue; a monitor compares every
// cycle the DUT shows out_valid and pops on the output handshake.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             cy;
      logic             zf;
      int               acc_cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             zero;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   logic rand_mode    = 1'b0;
   logic forced_ready = 1'b1;

   alu_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .zero      (zero)
   );

   // Clock generator
   always #5 clk = ~clk;

   // Edge counter used to measure accept-to-valid latency
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model from the opcode table, using plain integer arithmetic.
   function automatic exp_t model(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      exp_t        e;
      int unsigned ux;
      int unsigned uy;
      int unsigned s;
      ux = x;
      uy = y;
      e.cy = 1'b0;
      e.acc_cyc = 0;
      case (o)
         3'd0:    e.res = x & y;
         3'd1:    e.res = x | y;
         3'd2:    e.res = x ^ y;
         3'd3:    e.res = ~x;
         3'd4:    begin s = ux + uy; e.res = WIDTH'(s); e.cy = (s >= (32'd1 << WIDTH)); end
         3'd5:    begin e.res = WIDTH'(ux - uy); e.cy = (ux >= uy); end
         3'd6:    e.res = x;
         default: e.res = '0;
      endcase
      e.zf = (e.res == '0);
      return e;
   endfunction

   // Consumer ready: random or forced, changed just after the falling edge
   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         #1;
         out_ready = rand_mode ? 1'($urandom_range(0, 1)) : forced_ready;
      end
   end

   // Monitor: compare while out_valid, pop on handshake, check latency on rise
   initial begin
      logic prev_v;
      exp_t e;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_out: out_valid=1 with no pending request (t=%0t)", $time);
            end else begin
               e = sb[0];
               check("result",    64'(result),    64'(e.res));
               check("carry_out", 64'(carry_out), 64'(e.cy));
               check("zero",      64'(zero),      64'(e.zf));
               if (!prev_v) check("latency", 64'(cyc - e.acc_cyc), 64'(WIDTH));
               if (out_ready === 1'b1) void'(sb.pop_front());
            end
         end
         prev_v = (out_valid === 1'b1);
      end
   end

   // Drive a request and hold it until the DUT takes it; record expectation.
   task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      exp_t e;
      bit   done;
      done = 1'b0;
      @(posedge clk);
      #1;
      op = o;
      a = x;
      b = y;
      in_valid = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            @(posedge clk);
            #1;
            e = model(o, x, y);
            e.acc_cyc = cyc;
            sb.push_back(e);
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: request op=%0d not accepted", o);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d results still pending", sb.size());
      end
   endtask

   // Safety net against a hung DUT
   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Main stimulus
   initial begin
      logic [2:0] logic_ops [5];
      bit         seen;
      logic_ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
      rst_n = 1'b0;
      in_valid = 1'b0;
      op = 3'd0;
      a = '0;
      b = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result",    64'(result),    64'd0);
      check("rst_carry",     64'(carry_out), 64'd0);
      check("rst_zero",      64'(zero),      64'd1);
      rst_n = 1'b1;

      // Directed vectors
      issue(3'd4, 8'hFF, 8'h01);
      issue(3'd5, 8'h05, 8'h07);
      issue(3'd5, 8'h07, 8'h05);
      for (int i = 0; i < 5; i++) issue(logic_ops[i], 8'hF0, 8'h3C);
      issue(3'd7, 8'hAA, 8'h55);
      drain();

      // Back-pressure in DONE with a competing request on the input
      forced_ready = 1'b0;
      issue(3'd4, 8'h5A, 8'hA5);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         #2;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      check("stall_reached_done", 64'(seen), 64'd1);
      in_valid = 1'b1;
      op = 3'd1;
      a = 8'h11;
      b = 8'h22;
      repeat (5) begin
         @(negedge clk);
         #2;
         check("stall_in_ready",  64'(in_ready),  64'd0);
         check("stall_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      forced_ready = 1'b1;
      @(negedge clk);
      #2;
      @(posedge clk);
      @(negedge clk);
      #2;
      check("release_in_ready",  64'(in_ready),  64'd1);
      check("release_out_valid", 64'(out_valid), 64'd0);
      check("release_pending",   64'(sb.size()), 64'd0);

      // Reset sampled on the 3rd RUN edge aborts the operation
      issue(3'd4, 8'h12, 8'h34);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
      #2;
      check("abort_in_ready",  64'(in_ready),  64'd1);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_result",    64'(result),    64'd0);
      check("abort_zero",      64'(zero),      64'd1);
      issue(3'd4, 8'h12, 8'h34);
      drain();

      // Randomized traffic with random consumer back-pressure
      rand_mode = 1'b1;
      repeat (150) begin
         issue(3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      end
      drain();
      rand_mode = 1'b0;
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
